// File: rtl/mult_share_sched_pkg.sv
// mult_share_pkg: shared definitions for the multiplier-sharing scheduler.
//   state_t  - scheduler FSM encoding (IDLE=0, GRANT=1, START=2, WAIT=3, RESP=4)
//   prod_w() - product width for a given operand width
package mult_share_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    function automatic int prod_w(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/mult_share_sched_if.sv
// mult_share_sched_if: requester bus plus multiplier control bus of the scheduler.
//   Requester side : req, op_a, op_b (to scheduler); gnt, rsp_valid, result,
//                    rsp_err, busy (from scheduler)
//   Multiplier side: mul_start, mul_a, mul_b, mul_clr (from scheduler);
//                    mul_done, mul_product (to scheduler)
//   slave  modport : the scheduler
//   master modport : the environment (requesters + multiplier)
interface mult_share_sched_if
    import mult_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 8
);
    logic [NREQ-1:0]      req;
    logic [NREQ*W-1:0]    op_a;
    logic [NREQ*W-1:0]    op_b;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      rsp_valid;
    logic [prod_w(W)-1:0] result;
    logic                 rsp_err;
    logic                 busy;
    logic                 mul_start;
    logic [W-1:0]         mul_a;
    logic [W-1:0]         mul_b;
    logic                 mul_done;
    logic [prod_w(W)-1:0] mul_product;
    logic                 mul_clr;

    modport slave (
        input  req, op_a, op_b, mul_done, mul_product,
        output gnt, rsp_valid, result, rsp_err, busy,
               mul_start, mul_a, mul_b, mul_clr
    );

    modport master (
        output req, op_a, op_b, mul_done, mul_product,
        input  gnt, rsp_valid, result, rsp_err, busy,
               mul_start, mul_a, mul_b, mul_clr
    );
endinterface

// File: rtl/mult_share_sched_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req     - request vector
//   ptr     - index of the last requester served; search starts at ptr+1
//   win     - one-hot winner (zero when nothing requests)
//   win_idx - winner index
//   any     - at least one request present
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  win,
    output logic [IDX_W-1:0] win_idx,
    output logic             any
);
    always_comb begin
        logic [IDX_W-1:0] cand;
        cand    = '0;
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        // Walk the requesters in priority order; the first hit wins.
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NREQ);
            if (!any && req[cand]) begin
                any     = 1'b1;
                win_idx = cand;
            end
        end
        if (any) begin
            win[win_idx] = 1'b1;
        end
    end
endmodule

// File: rtl/mult_share_sched.sv
// mult_share_sched: round-robin scheduler sharing one sequential multiplier
// among NREQ requesters.
//   clk   - clock, rising edge
//   reset - asynchronous, active-high
//   bus   - mult_share_sched_if.slave: requester bus (req/op_a/op_b in,
//           gnt/rsp_valid/result/rsp_err/busy out) and multiplier control
//           (mul_start/mul_a/mul_b/mul_clr out, mul_done/mul_product in)
// Flow: IDLE -> GRANT -> START -> WAIT -> RESP -> IDLE. Outputs are decoded
// from the state register; a watchdog aborts WAIT after TIMEOUT cycles.
module mult_share_sched
    import mult_share_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 255
) (
    input logic              clk,
    input logic              reset,
    mult_share_sched_if.slave bus
);
    localparam int IDX_W = $clog2(NREQ);
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam int PW    = prod_w(W);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(NREQ - 1);

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  owner;
    logic [NREQ-1:0]   owner_1h;
    logic [IDX_W-1:0]  ptr;
    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;
    logic [PW-1:0]     result_q;
    logic              err_q;
    logic [WD_W-1:0]   wd;
    logic              wd_expired;

    logic [NREQ-1:0]   win;
    logic [IDX_W-1:0]  win_idx;
    logic              any;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (bus.req),
        .ptr     (ptr),
        .win     (win),
        .win_idx (win_idx),
        .any     (any)
    );

    assign wd_expired = (wd == WD_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and Moore output decode.
    always_comb begin
        state_nxt     = state;
        bus.gnt       = '0;
        bus.rsp_valid = '0;
        bus.rsp_err   = 1'b0;
        bus.busy      = (state != S_IDLE);
        bus.mul_start = 1'b0;
        bus.mul_clr   = 1'b0;
        unique case (state)
            S_IDLE:  if (any) state_nxt = S_GRANT;
            S_GRANT: begin
                bus.gnt   = owner_1h;
                state_nxt = S_START;
            end
            S_START: begin
                bus.mul_start = 1'b1;
                state_nxt     = S_WAIT;
            end
            // Done has priority over a simultaneous watchdog expiry.
            S_WAIT:  if (bus.mul_done || wd_expired) state_nxt = S_RESP;
            S_RESP: begin
                bus.rsp_valid = owner_1h;
                bus.rsp_err   = err_q;
                bus.mul_clr   = 1'b1;
                state_nxt     = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Owner/operand capture, watchdog, result and pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner    <= '0;
            owner_1h <= '0;
            ptr      <= PTR_INIT;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            wd       <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (any) begin
                        owner    <= win_idx;
                        owner_1h <= win;
                        a_q      <= bus.op_a[win_idx*W +: W];
                        b_q      <= bus.op_b[win_idx*W +: W];
                    end
                end
                S_START: wd <= '0;
                S_WAIT: begin
                    if (bus.mul_done) begin
                        result_q <= bus.mul_product;
                        err_q    <= 1'b0;
                    end else if (wd_expired) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                // The pointer moves only once the job has completed.
                S_RESP: ptr <= owner;
                default: ;
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.mul_a  = a_q;
    assign bus.mul_b  = b_q;
endmodule

// File: tb/tb_mult_share_sched.sv
`timescale 1ns/1ps
module tb_mult_share_sched;
    import mult_share_pkg::*;

    localparam int NREQ    = 4;
    localparam int W       = 8;
    localparam int TIMEOUT = 16;
    localparam int PW      = prod_w(W);

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mult_share_sched_if #(.NREQ(NREQ), .W(W)) bus();

    mult_share_sched #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- environment: requesters + multiplier ----------------
    int pend [NREQ];
    logic [W-1:0] opa [NREQ];
    logic [W-1:0] opb [NREQ];
    int req_rise_cyc [NREQ];
    int dly;          // cycles from start to done; <=0 means never
    int stale_hold;   // cycles done stays high after a clear
    int mcnt, mstale;
    logic mdone;
    logic [PW-1:0] mprod;

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            bus.req[i]          = (pend[i] > 0);
            bus.op_a[i*W +: W]  = opa[i];
            bus.op_b[i*W +: W]  = opb[i];
        end
        bus.mul_done    = mdone;
        bus.mul_product = mprod;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (reset) begin
            mcnt = 0; mstale = 0; mdone = 1'b0;
        end else if (bus.mul_clr) begin
            mcnt = 0;
            if (stale_hold > 0) begin
                mstale = stale_hold; mdone = 1'b1; mprod = 16'hBEEF;
            end else begin
                mdone = 1'b0;
            end
        end else begin
            if (mstale > 0) begin
                mstale--;
                if (mstale == 0) mdone = 1'b0;
            end
            if (bus.mul_start) mcnt = dly;
            else if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) begin
                    mdone = 1'b1;
                    mprod = {8'd0, bus.mul_a} * {8'd0, bus.mul_b};
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (bus.gnt[i] && pend[i] > 0) begin
                pend[i]--;
                opa[i] = opa[i] + 8'd13;
                opb[i] = opb[i] + 8'd29;
            end
            if (pend[i] > 0 && !bus.req[i]) req_rise_cyc[i] = cyc;
        end
        drive();
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int rr_model(input logic [NREQ-1:0] r, input int p);
        for (int k = 1; k <= NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return 0;
    endfunction

    logic [NREQ-1:0]   last_req;
    logic [NREQ*W-1:0] last_opa, last_opb;
    bit   last_idle, last_done, job_active;
    int   g_cyc, j_owner, m_ptr;
    logic [W-1:0]  j_a, j_b;
    logic [PW-1:0] m_result;

    int gnt_q[$];
    int gnt_cyc_q[$];
    int start_cyc, rsp_cnt, rsp_cyc, rsp_owner;
    logic [PW-1:0] rsp_result;
    logic rsp_errv;

    initial begin
        rsp_cnt = 0; start_cyc = 0; rsp_cyc = 0; rsp_owner = 0;
        rsp_result = '0; rsp_errv = 1'b0;
    end

    always @(negedge clk) begin : cmp
        logic [NREQ-1:0] e_gnt, e_rsp;
        bit e_busy, e_start, e_err, e_rspb;
        int age;
        if (reset) begin
            chk("rst_gnt", bus.gnt, 0);
            chk("rst_rsp_valid", bus.rsp_valid, 0);
            chk("rst_rsp_err", bus.rsp_err, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_mul_start", bus.mul_start, 0);
            chk("rst_mul_clr", bus.mul_clr, 0);
            chk("rst_result", bus.result, 0);
            chk("rst_mul_a", bus.mul_a, 0);
            chk("rst_mul_b", bus.mul_b, 0);
            job_active = 0; m_ptr = NREQ - 1; m_result = '0;
            last_idle = 1; last_req = '0; last_done = 0;
        end else begin
            e_gnt = '0; e_rsp = '0; e_busy = 0; e_start = 0; e_err = 0; e_rspb = 0; age = 0;
            if (job_active) begin
                age = cyc - g_cyc;
                e_busy = 1;
                if (age == 1) e_start = 1;
                else if (age >= 3 && (last_done || age == TIMEOUT + 2)) begin
                    e_rspb = 1; e_err = !last_done; e_rsp = onehot(j_owner);
                end
            end else if (last_idle && last_req != '0) begin
                j_owner = rr_model(last_req, m_ptr);
                j_a = last_opa[j_owner*W +: W];
                j_b = last_opb[j_owner*W +: W];
                job_active = 1; g_cyc = cyc;
                e_gnt = onehot(j_owner); e_busy = 1;
            end
            chk("gnt", bus.gnt, e_gnt);
            chk("busy", bus.busy, e_busy);
            chk("mul_start", bus.mul_start, e_start);
            chk("rsp_valid", bus.rsp_valid, e_rsp);
            chk("mul_clr", bus.mul_clr, e_rspb);
            if (e_rspb) begin
                chk("rsp_err", bus.rsp_err, e_err);
                m_result = e_err ? '0 : {8'd0, j_a} * {8'd0, j_b};
            end
            chk("result", bus.result, m_result);
            if (job_active && cyc > g_cyc) begin
                chk("mul_a", bus.mul_a, j_a);
                chk("mul_b", bus.mul_b, j_b);
            end
            if (e_rspb) begin
                job_active = 0; m_ptr = j_owner;
            end
            last_idle = !e_busy;
            last_req  = bus.req;
            last_opa  = bus.op_a;
            last_opb  = bus.op_b;
            last_done = bus.mul_done;
            if (bus.gnt != '0) begin
                gnt_q.push_back($clog2(bus.gnt));
                gnt_cyc_q.push_back(cyc);
            end
            if (bus.mul_start) start_cyc = cyc;
            if (bus.rsp_valid != '0) begin
                rsp_cnt++;
                rsp_cyc    = cyc;
                rsp_owner  = $clog2(bus.rsp_valid);
                rsp_result = bus.result;
                rsp_errv   = bus.rsp_err;
            end
        end
    end

    task automatic wait_rsp(input int target, input int limit, input string name);
        int k;
        k = 0;
        while (rsp_cnt < target && k < limit) begin
            tick();
            k++;
        end
        chk({name, "_done_in_time"}, (rsp_cnt >= target), 1);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "simulation time limit");
    end

    // ---------------- directed tests ----------------
    initial begin
        int n, qb;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 0; opa[i] = '0; opb[i] = '0; req_rise_cyc[i] = 0;
        end
        dly = 8; stale_hold = 0; mcnt = 0; mstale = 0; mdone = 1'b0; mprod = '0;
        drive();
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // 1: single request, 7*6, done 8 cycles after start
        opa[0] = 8'd7; opb[0] = 8'd6; pend[0] = 1; dly = 8;
        n = rsp_cnt;
        tick();
        wait_rsp(n + 1, 100, "t1");
        chk("t1_gnt_latency", gnt_cyc_q[gnt_cyc_q.size()-1] - req_rise_cyc[0], 1);
        chk("t1_rsp_latency", rsp_cyc - gnt_cyc_q[gnt_cyc_q.size()-1], 10);
        chk("t1_owner", rsp_owner, 0);
        chk("t1_result", rsp_result, 42);
        chk("t1_err", rsp_errv, 0);

        // 2: all four request from reset pointer, fastest multiplier
        reset = 1'b1; tick(); tick(); reset = 1'b0; tick();
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = 8'(i * 16 + 3); opb[i] = 8'(200 - i * 9); pend[i] = 2;
        end
        dly = 1;
        n = rsp_cnt; qb = gnt_q.size();
        tick();
        wait_rsp(n + 8, 200, "t2");
        chk("t2_order0", gnt_q[qb + 0], 0);
        chk("t2_order1", gnt_q[qb + 1], 1);
        chk("t2_order2", gnt_q[qb + 2], 2);
        chk("t2_order3", gnt_q[qb + 3], 3);
        chk("t2_order4", gnt_q[qb + 4], 0);
        chk("t2_job_spacing", gnt_cyc_q[qb + 1] - gnt_cyc_q[qb], 5);
        chk("t2_last_result", rsp_result, 16'(({8'd0, opa[3] - 8'd13}) * ({8'd0, opb[3] - 8'd29})));
        repeat (2) tick();

        // 3: req[2] repeats, req[1] joins mid-job and is not starved
        dly = 4; pend[2] = 3;
        n = rsp_cnt; qb = gnt_q.size();
        tick();
        repeat (3) tick();
        pend[1] = 1;
        wait_rsp(n + 4, 200, "t3");
        chk("t3_order0", gnt_q[qb + 0], 2);
        chk("t3_order1", gnt_q[qb + 1], 1);
        chk("t3_order2", gnt_q[qb + 2], 2);
        chk("t3_order3", gnt_q[qb + 3], 2);
        repeat (2) tick();

        // 4: watchdog abort, then done on the last WAIT cycle
        dly = -1; pend[3] = 1;
        n = rsp_cnt;
        tick();
        wait_rsp(n + 1, 100, "t4a");
        chk("t4a_abort_latency", rsp_cyc - start_cyc, TIMEOUT + 1);
        chk("t4a_err", rsp_errv, 1);
        chk("t4a_result", rsp_result, 0);
        chk("t4a_owner", rsp_owner, 3);
        repeat (2) tick();
        dly = TIMEOUT; opa[3] = 8'd15; opb[3] = 8'd17; pend[3] = 1;
        n = rsp_cnt;
        tick();
        wait_rsp(n + 1, 100, "t4b");
        chk("t4b_latency", rsp_cyc - start_cyc, TIMEOUT + 1);
        chk("t4b_err", rsp_errv, 0);
        chk("t4b_result", rsp_result, 255);
        repeat (2) tick();

        // 5: done left high after clear is ignored until WAIT
        stale_hold = 4; dly = 3; opa[0] = 8'd10; opb[0] = 8'd20; pend[0] = 2;
        n = rsp_cnt;
        tick();
        wait_rsp(n + 1, 100, "t5a");
        chk("t5a_result", rsp_result, 200);
        wait_rsp(n + 2, 100, "t5b");
        chk("t5b_latency", rsp_cyc - start_cyc, 4);
        chk("t5b_result", rsp_result, 1127);
        stale_hold = 0;
        repeat (6) tick();

        // 6: reset during WAIT abandons the job
        dly = -1; pend[1] = 1;
        tick();
        repeat (6) tick();
        chk("t6_in_job", bus.busy, 1);
        n = rsp_cnt;
        reset = 1'b1;
        #1;
        chk("t6_async_busy", bus.busy, 0);
        chk("t6_async_mul_a", bus.mul_a, 0);
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("t6_no_rsp", rsp_cnt, n);
        dly = 2; pend[0] = 1; pend[1] = 1; opa[0] = 8'd9; opb[0] = 8'd9;
        qb = gnt_q.size();
        tick();
        wait_rsp(n + 2, 100, "t6");
        chk("t6_first", gnt_q[qb], 0);
        chk("t6_second", gnt_q[qb + 1], 1);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
